// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone memory arbiter.
// No logic here, so no latency and no backpressure of its own.
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_0 = 2'd1,
        GNT_1 = 2'd2
    } state_t;

    localparam int          TIMEOUT_DEFAULT = 255;
    localparam logic [31:0] ABORT_DATA      = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Counts unacked strobe cycles and fires a one-cycle expire when the limit is hit.
// Latency: expire is combinational in the limit cycle; no backpressure, clr wins over inc.
module wb_arb_watchdog
    import wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic expire
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count;

    // The limit cycle is itself the Nth waiting cycle, so compare against N-1.
    assign expire = inc && (count == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || expire) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter (instruction/data bridge) onto one shared slave, with watchdog abort.
// Latency: one cycle to grant from IDLE, zero on handoff; backpressure: grant locked while cyc is high.
module wb_mem_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter bit PRIO_DATA      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_ack_o,

    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_ack_o,

    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_ack_i,

    output logic                  timeout_o
);

    localparam logic [DATA_WIDTH-1:0] ABORT_WORD = DATA_WIDTH'(ABORT_DATA);

    state_t state, next_state;
    logic   last_grant;
    logic   init_done;
    logic   req0, req1;
    logic   wait_ack;
    logic   wd_clr;
    logic   expire;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // init_done holds off the first grant until the second edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            init_done  <= 1'b0;
        end else begin
            state     <= next_state;
            init_done <= 1'b1;
            if ((next_state != state) && (next_state != IDLE)) begin
                last_grant <= (next_state == GNT_1);
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (init_done) begin
                    if (req0 && req1) begin
                        next_state = (PRIO_DATA || !last_grant) ? GNT_1 : GNT_0;
                    end else if (req0) begin
                        next_state = GNT_0;
                    end else if (req1) begin
                        next_state = GNT_1;
                    end
                end
            end
            GNT_0: begin
                if (!m0_cyc_i) begin
                    next_state = req1 ? GNT_1 : IDLE;
                end
            end
            GNT_1: begin
                if (!m1_cyc_i) begin
                    next_state = req0 ? GNT_0 : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Waiting is judged on the master's strobe, not s_stb_o, since the abort masks s_stb_o.
    always_comb begin
        wait_ack = 1'b0;
        case (state)
            GNT_0:   wait_ack = req0 & ~s_ack_i;
            GNT_1:   wait_ack = req1 & ~s_ack_i;
            default: wait_ack = 1'b0;
        endcase
    end

    assign wd_clr = (state == IDLE) || (next_state != state) || s_ack_i;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .inc    (wait_ack),
        .clr    (wd_clr),
        .expire (expire)
    );

    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_data_o  = '0;
        m0_ack_o  = 1'b0;
        m0_data_o = '0;
        m1_ack_o  = 1'b0;
        m1_data_o = '0;
        timeout_o = expire;
        case (state)
            GNT_0: begin
                s_cyc_o   = m0_cyc_i & ~expire;
                s_stb_o   = m0_stb_i & ~expire;
                s_we_o    = m0_we_i;
                s_addr_o  = m0_addr_i;
                s_data_o  = m0_data_i;
                m0_ack_o  = m0_cyc_i & (s_ack_i | expire);
                m0_data_o = expire ? ABORT_WORD : s_data_i;
            end
            GNT_1: begin
                s_cyc_o   = m1_cyc_i & ~expire;
                s_stb_o   = m1_stb_i & ~expire;
                s_we_o    = m1_we_i;
                s_addr_o  = m1_addr_i;
                s_data_o  = m1_data_i;
                m1_ack_o  = m1_cyc_i & (s_ack_i | expire);
                m1_data_o = expire ? ABORT_WORD : s_data_i;
            end
            default: begin
                timeout_o = 1'b0;
            end
        endcase
    end

endmodule
